// File: rtl/m4_tpm_regs.sv
`timescale 1ns/1ps
// m4_tpm_regs: M4-side Wishbone-classic slave for the TwPM command handshake.
//   Exposes STATUS (exec/abort pending W1C, complete busy, irq enable), the
//   op type / locality / buffer length latched on each exec rising edge, a
//   COMPLETE trigger that emits a fixed-width pulse to the LPC side, and a
//   window onto the shared command buffer RAM.
// Ports:
//   clk_i, nrst_i            clock, async active-low reset
//   wb_*                     32-bit Wishbone classic slave, ack after 1 wait
//                            state (2 for RAM reads)
//   op_type_i, locality_i,
//   buf_len_i, exec_i,
//   abort_i                  command handshake from the LPC-side registers
//   complete_o               completion pulse, COMPLETE_PULSE_WIDTH cycles
//   irq_o                    registered interrupt to the M4
//   ram_*                    command buffer RAM port (1-cycle read latency)
module m4_tpm_regs #(
    parameter int unsigned            ADDR_WIDTH            = 17,
    parameter int unsigned            RAM_ADDR_WIDTH        = 11,
    parameter logic [ADDR_WIDTH-1:0]  STATUS_REG_ADDRESS    = 17'h00000,
    parameter logic [ADDR_WIDTH-1:0]  OP_TYPE_REG_ADDRESS   = 17'h00004,
    parameter logic [ADDR_WIDTH-1:0]  LOCALITY_REG_ADDRESS  = 17'h00008,
    parameter logic [ADDR_WIDTH-1:0]  BUF_SIZE_REG_ADDRESS  = 17'h0000C,
    parameter logic [ADDR_WIDTH-1:0]  COMPLETE_REG_ADDRESS  = 17'h00040,
    parameter logic [ADDR_WIDTH-1:0]  FPGA_RAM_BASE_ADDRESS = 17'h00800,
    parameter logic [31:0]            DEFAULT_READ_VALUE    = 32'hBADFABAC,
    parameter int unsigned            COMPLETE_PULSE_WIDTH  = 20
) (
    input  logic                      clk_i,
    input  logic                      nrst_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic [3:0]                wb_sel_i,
    input  logic [31:0]               wb_dat_i,
    output logic [31:0]               wb_dat_o,
    output logic                      wb_ack_o,
    input  logic [3:0]                op_type_i,
    input  logic [3:0]                locality_i,
    input  logic [RAM_ADDR_WIDTH-1:0] buf_len_i,
    input  logic                      exec_i,
    input  logic                      abort_i,
    output logic                      complete_o,
    output logic                      irq_o,
    output logic [RAM_ADDR_WIDTH-3:0] ram_addr_o,
    output logic [31:0]               ram_wd_o,
    output logic [3:0]                ram_be_o,
    output logic                      ram_we_o,
    input  logic [31:0]               ram_rd_i
);

    localparam int unsigned CNT_W = (COMPLETE_PULSE_WIDTH > 1) ? $clog2(COMPLETE_PULSE_WIDTH) : 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COMPLETE_PULSE_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RAM_RD, ACK} bus_state_t;
    typedef enum logic [2:0] {K_NONE, K_STATUS, K_OP_TYPE, K_LOCALITY, K_BUF_SIZE, K_COMPLETE} reg_kind_t;

    bus_state_t state;
    reg_kind_t  hit_kind, acc_kind;
    logic       acc_we, acc_sel0, acc_sel_any;
    logic [2:0] acc_wbits;      // {dat[3], dat[1], dat[0]}: the only STATUS bits a write touches

    logic exec_s1, exec_s2, abort_s1, abort_s2;
    logic [3:0] op_type_s1, locality_s1, op_type_q, locality_q;
    logic [RAM_ADDR_WIDTH-1:0] buf_len_s1, buf_size_q;
    logic exec_pending, abort_pending, irq_en;
    logic [CNT_W-1:0] pulse_cnt;

    logic exec_edge, abort_edge, in_win, ram_hit, ram_access;
    logic reg_wr, status_wr, complete_start;
    logic [31:0] rd_mux;
    logic unused_adr_bits;

    assign unused_adr_bits = ^wb_adr_i[1:0];

    // ---------------- address decode ----------------
    assign in_win = (wb_adr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH] ==
                     FPGA_RAM_BASE_ADDRESS[ADDR_WIDTH-1:RAM_ADDR_WIDTH]);

    always_comb begin
        hit_kind = K_NONE;
        if (wb_adr_i[ADDR_WIDTH-1:2] == STATUS_REG_ADDRESS[ADDR_WIDTH-1:2])
            hit_kind = K_STATUS;
        else if (wb_adr_i[ADDR_WIDTH-1:2] == OP_TYPE_REG_ADDRESS[ADDR_WIDTH-1:2])
            hit_kind = K_OP_TYPE;
        else if (wb_adr_i[ADDR_WIDTH-1:2] == LOCALITY_REG_ADDRESS[ADDR_WIDTH-1:2])
            hit_kind = K_LOCALITY;
        else if (wb_adr_i[ADDR_WIDTH-1:2] == BUF_SIZE_REG_ADDRESS[ADDR_WIDTH-1:2])
            hit_kind = K_BUF_SIZE;
        else if (wb_adr_i[ADDR_WIDTH-1:2] == COMPLETE_REG_ADDRESS[ADDR_WIDTH-1:2])
            hit_kind = K_COMPLETE;
    end

    assign ram_hit = in_win && (hit_kind == K_NONE);

    always_comb begin
        rd_mux = DEFAULT_READ_VALUE;
        case (hit_kind)
            K_STATUS:   rd_mux = {28'b0, irq_en, complete_o, abort_pending, exec_pending};
            K_OP_TYPE:  rd_mux = {28'b0, op_type_q};
            K_LOCALITY: rd_mux = {28'b0, locality_q};
            K_BUF_SIZE: rd_mux = {{(32-RAM_ADDR_WIDTH){1'b0}}, buf_size_q};
            K_COMPLETE: rd_mux = {31'b0, complete_o};
            default:    rd_mux = DEFAULT_READ_VALUE;
        endcase
    end

    // RAM port is driven straight from the bus in IDLE so the registered RAM
    // read lands in RAM_RD; gated by nrst_i so it stays 0 during reset.
    assign ram_access = nrst_i & wb_cyc_i & wb_stb_i & (state == IDLE) & ram_hit;
    assign ram_addr_o = ram_access ? wb_adr_i[RAM_ADDR_WIDTH-1:2] : '0;
    assign ram_we_o   = ram_access & wb_we_i;
    assign ram_be_o   = ram_we_o ? wb_sel_i : '0;
    assign ram_wd_o   = ram_we_o ? wb_dat_i : '0;

    // ---------------- bus FSM ----------------
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state       <= IDLE;
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= '0;
            acc_kind    <= K_NONE;
            acc_we      <= 1'b0;
            acc_sel0    <= 1'b0;
            acc_sel_any <= 1'b0;
            acc_wbits   <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        acc_kind    <= hit_kind;
                        acc_we      <= wb_we_i;
                        acc_sel0    <= wb_sel_i[0];
                        acc_sel_any <= |wb_sel_i;
                        acc_wbits   <= {wb_dat_i[3], wb_dat_i[1:0]};
                        if (ram_hit && !wb_we_i) begin
                            state <= RAM_RD;
                        end else begin
                            state    <= ACK;
                            wb_ack_o <= 1'b1;
                            wb_dat_o <= rd_mux;
                        end
                    end
                end
                RAM_RD: begin
                    wb_dat_o <= ram_rd_i;
                    wb_ack_o <= 1'b1;
                    state    <= ACK;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Register writes commit at the end of the ack cycle, so a COMPLETE pulse
    // starts the cycle after the ack.
    assign reg_wr         = (state == ACK) && acc_we;
    assign status_wr      = reg_wr && (acc_kind == K_STATUS) && acc_sel0;
    assign complete_start = reg_wr && (acc_kind == K_COMPLETE) && acc_sel_any && !complete_o;

    assign exec_edge  = exec_s1 & ~exec_s2;
    assign abort_edge = abort_s1 & ~abort_s2;

    // ---------------- handshake, status, pulse, irq ----------------
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            exec_s1       <= 1'b0;
            exec_s2       <= 1'b0;
            abort_s1      <= 1'b0;
            abort_s2      <= 1'b0;
            op_type_s1    <= '0;
            locality_s1   <= '0;
            buf_len_s1    <= '0;
            op_type_q     <= '0;
            locality_q    <= '0;
            buf_size_q    <= '0;
            exec_pending  <= 1'b0;
            abort_pending <= 1'b0;
            irq_en        <= 1'b0;
            irq_o         <= 1'b0;
            complete_o    <= 1'b0;
            pulse_cnt     <= '0;
        end else begin
            // Fields are registered alongside exec so the latch sees the
            // values that accompanied the exec rising edge.
            exec_s1     <= exec_i;
            exec_s2     <= exec_s1;
            abort_s1    <= abort_i;
            abort_s2    <= abort_s1;
            op_type_s1  <= op_type_i;
            locality_s1 <= locality_i;
            buf_len_s1  <= buf_len_i;

            if (exec_edge) begin
                op_type_q  <= op_type_s1;
                locality_q <= locality_s1;
                buf_size_q <= buf_len_s1;
            end

            if (abort_edge)
                exec_pending <= 1'b0;
            else if (exec_edge)
                exec_pending <= 1'b1;
            else if ((status_wr && acc_wbits[0]) || complete_start)
                exec_pending <= 1'b0;

            if (abort_edge)
                abort_pending <= 1'b1;
            else if (status_wr && acc_wbits[1])
                abort_pending <= 1'b0;

            if (status_wr)
                irq_en <= acc_wbits[2];

            irq_o <= irq_en & (exec_pending | abort_pending);

            if (complete_start) begin
                complete_o <= 1'b1;
                pulse_cnt  <= PULSE_LOAD;
            end else if (complete_o) begin
                if (pulse_cnt == '0)
                    complete_o <= 1'b0;
                else
                    pulse_cnt <= pulse_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_m4_tpm_regs.sv
`timescale 1ns/1ps
module tb_m4_tpm_regs;

    localparam logic [16:0] A_STATUS   = 17'h00000;
    localparam logic [16:0] A_OP_TYPE  = 17'h00004;
    localparam logic [16:0] A_LOCALITY = 17'h00008;
    localparam logic [16:0] A_BUF_SIZE = 17'h0000C;
    localparam logic [16:0] A_COMPLETE = 17'h00040;

    logic        clk_i = 1'b0;
    logic        nrst_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [16:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i, wb_dat_o;
    logic        wb_ack_o;
    logic [3:0]  op_type_i, locality_i;
    logic [10:0] buf_len_i;
    logic        exec_i, abort_i;
    logic        complete_o, irq_o;
    logic [8:0]  ram_addr_o;
    logic [31:0] ram_wd_o;
    logic [3:0]  ram_be_o;
    logic        ram_we_o;
    logic [31:0] ram_rd_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    m4_tpm_regs dut (
        .clk_i      (clk_i),
        .nrst_i     (nrst_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .op_type_i  (op_type_i),
        .locality_i (locality_i),
        .buf_len_i  (buf_len_i),
        .exec_i     (exec_i),
        .abort_i    (abort_i),
        .complete_o (complete_o),
        .irq_o      (irq_o),
        .ram_addr_o (ram_addr_o),
        .ram_wd_o   (ram_wd_o),
        .ram_be_o   (ram_be_o),
        .ram_we_o   (ram_we_o),
        .ram_rd_i   (ram_rd_i)
    );

    // Command buffer RAM model: registered read, byte-lane writes.
    logic [31:0] mem [0:511];
    logic        preloaded = 1'b0;
    always @(posedge clk_i) begin
        if (!preloaded) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'hCAFE0000 | 32'(i);
            mem[1]    <= 32'h12345678;
            preloaded <= 1'b1;
        end else if (ram_we_o) begin
            for (int b = 0; b < 4; b++)
                if (ram_be_o[b]) mem[ram_addr_o][b*8 +: 8] <= ram_wd_o[b*8 +: 8];
        end
        ram_rd_i <= mem[ram_addr_o];
    end

    int we_cnt = 0;
    int hi_cnt = 0;
    always @(posedge clk_i) begin
        if (ram_we_o)   we_cnt++;
        if (complete_o) hi_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic        snap_we;
    logic [3:0]  snap_be;
    logic [8:0]  snap_addr;

    // One Wishbone classic transfer. lat is the cycle number of the ack with
    // the strobe cycle counted as 1; 0 means no ack within the budget.
    task automatic bus_xfer(input logic we, input logic [16:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, output logic [31:0] rdat, output int lat);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
        #1;
        snap_we = ram_we_o; snap_be = ram_be_o; snap_addr = ram_addr_o;
        lat  = 0;
        rdat = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            if (wb_ack_o) begin
                lat  = i + 2;
                rdat = wb_dat_o;
                break;
            end
        end
        @(negedge clk_i);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wait_complete_fall(output logic fell);
        fell = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk_i); #1;
            if (!complete_o) begin
                fell = 1'b1;
                break;
            end
        end
    endtask

    logic [31:0] rd;
    int          lat, base, irq_lat;
    logic        fell, ack_seen;

    initial begin
        nrst_i = 1'b0;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
        op_type_i = '0; locality_i = '0; buf_len_i = '0; exec_i = 0; abort_i = 0;
        repeat (3) @(negedge clk_i);
        check("rst_complete", complete_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_ack", wb_ack_o, 0);
        nrst_i = 1'b1;

        // Basic reads and ack latency
        bus_xfer(0, A_STATUS, 4'hF, 0, rd, lat);
        check("status_rst_val", rd, 0);
        check("status_lat", lat, 2);
        bus_xfer(0, 17'h00044, 4'hF, 0, rd, lat);
        check("unmapped_rd", rd, 32'hBADFABAC);
        check("unmapped_lat", lat, 2);
        bus_xfer(0, 17'h00800, 4'hF, 0, rd, lat);
        check("ram_rd_w0", rd, 32'hCAFE0000);
        check("ram_rd_lat", lat, 3);

        // Latching on exec edge; inputs change afterwards
        @(negedge clk_i);
        op_type_i = 4'h2; locality_i = 4'h1; buf_len_i = 11'd64; exec_i = 1'b1;
        @(posedge clk_i); #1;
        op_type_i = 4'hF; locality_i = 4'hE; buf_len_i = 11'h7FF;
        repeat (3) @(posedge clk_i);
        bus_xfer(0, A_OP_TYPE, 4'hF, 0, rd, lat);  check("op_type", rd, 2);
        bus_xfer(0, A_LOCALITY, 4'hF, 0, rd, lat); check("locality", rd, 1);
        bus_xfer(0, A_BUF_SIZE, 4'hF, 0, rd, lat); check("buf_size", rd, 64);
        bus_xfer(0, A_STATUS, 4'hF, 0, rd, lat);   check("status_exec", rd, 1);
        bus_xfer(1, A_OP_TYPE, 4'hF, 32'hF, rd, lat);
        check("ro_wr_lat", lat, 2);
        bus_xfer(0, A_OP_TYPE, 4'hF, 0, rd, lat);  check("op_type_ro", rd, 2);

        // Interrupt
        bus_xfer(1, A_STATUS, 4'hF, 32'h1, rd, lat);
        @(negedge clk_i); exec_i = 1'b0;
        repeat (3) @(posedge clk_i);
        bus_xfer(1, A_STATUS, 4'hF, 32'h8, rd, lat);
        repeat (3) @(posedge clk_i); #1;
        check("irq_idle", irq_o, 0);
        @(negedge clk_i); exec_i = 1'b1;
        irq_lat = 99;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_i); #1;
            if (irq_o) begin
                irq_lat = k;
                break;
            end
        end
        check("irq_lat", irq_lat, 2);
        bus_xfer(1, A_STATUS, 4'hF, 32'h1, rd, lat);
        repeat (3) @(posedge clk_i); #1;
        check("irq_cleared", irq_o, 0);

        // Complete pulse
        @(negedge clk_i); exec_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); exec_i = 1'b1;
        repeat (3) @(posedge clk_i);
        bus_xfer(0, A_STATUS, 4'hF, 0, rd, lat);   check("status_pre_cpl", rd, 1);
        base = hi_cnt;
        bus_xfer(1, A_COMPLETE, 4'h1, 32'h1, rd, lat);
        check("cpl_not_early", complete_o, 0);
        @(posedge clk_i); #1;
        check("cpl_start", complete_o, 1);
        bus_xfer(0, A_STATUS, 4'hF, 0, rd, lat);   check("status_busy", rd, 4);
        bus_xfer(0, A_COMPLETE, 4'hF, 0, rd, lat); check("cpl_rd_busy", rd, 1);
        wait_complete_fall(fell);
        check("cpl_fell", fell, 1);
        check("cpl_width", hi_cnt - base, 20);

        base = hi_cnt;
        bus_xfer(1, A_COMPLETE, 4'hF, 32'h1, rd, lat);
        repeat (3) @(negedge clk_i);
        bus_xfer(1, A_COMPLETE, 4'hF, 32'h1, rd, lat);
        check("cpl_busy_wr_lat", lat, 2);
        wait_complete_fall(fell);
        check("cpl_no_extend", hi_cnt - base, 20);
        bus_xfer(0, A_COMPLETE, 4'hF, 0, rd, lat); check("cpl_rd_idle", rd, 0);

        // RAM window writes
        base = we_cnt;
        bus_xfer(1, 17'h00804, 4'b0011, 32'hDEADBEEF, rd, lat);
        check("ram_we", snap_we, 1);
        check("ram_be", snap_be, 4'b0011);
        check("ram_addr", snap_addr, 1);
        check("ram_wr_lat", lat, 2);
        check("ram_we_count", we_cnt - base, 1);
        bus_xfer(0, 17'h00804, 4'hF, 0, rd, lat);
        check("ram_rdback", rd, 32'h1234BEEF);
        check("ram_rdback_lat", lat, 3);
        base = we_cnt;
        bus_xfer(1, 17'h01000, 4'hF, 32'h55AA55AA, rd, lat);
        check("out_win_we", snap_we, 0);
        check("out_win_we_count", we_cnt - base, 0);
        check("out_win_lat", lat, 2);

        // Abort coinciding with exec
        @(negedge clk_i); exec_i = 1'b0; abort_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); exec_i = 1'b1; abort_i = 1'b1;
        repeat (3) @(posedge clk_i);
        bus_xfer(0, A_STATUS, 4'hF, 0, rd, lat);   check("status_abort", rd, 2);
        bus_xfer(1, A_STATUS, 4'hF, 32'h2, rd, lat);
        bus_xfer(0, A_STATUS, 4'hF, 0, rd, lat);   check("status_abort_w1c", rd, 0);

        // Reset mid-pulse and mid-access
        @(negedge clk_i); exec_i = 1'b0; abort_i = 1'b0;
        bus_xfer(1, A_COMPLETE, 4'hF, 32'h1, rd, lat);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 17'h00808; wb_sel_i = 4'hF;
        @(posedge clk_i); #2;
        nrst_i = 1'b0;
        #1;
        check("rst_mid_complete", complete_o, 0);
        check("rst_mid_ack", wb_ack_o, 0);
        check("rst_mid_ram_addr", ram_addr_o, 0);
        ack_seen = 1'b0;
        repeat (3) begin
            @(posedge clk_i); #1;
            ack_seen = ack_seen | wb_ack_o;
        end
        check("rst_no_ack", ack_seen, 0);
        @(negedge clk_i);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        nrst_i = 1'b1;
        bus_xfer(0, A_STATUS, 4'hF, 0, rd, lat);   check("status_post_rst", rd, 0);
        bus_xfer(0, A_OP_TYPE, 4'hF, 0, rd, lat);  check("op_type_post_rst", rd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
